// File: rtl/bfloat16_tanh_loader_pkg.sv
// Shared types for the bfloat16 tanh table loader.
// Holds the FSM state enum, size defaults and the bfloat16 word type.
package bfloat16_tanh_loader_pkg;

    localparam int DEF_NUM_ENTRIES = 32;
    localparam int DEF_ADDR_W      = 5;

    typedef logic [15:0] bf16_t;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        CK_HI,
        CK_LO,
        FIN
    } state_t;

endpackage

// File: rtl/bfloat16_tanh_loader_byte_pair_assembler.sv
// Joins a high byte and a low byte into one 16-bit word.
// Ports: clk, rst_x, data (byte), hi_en, lo_en -> word, word_valid (1-cycle pulse).
module byte_pair_assembler
    import bfloat16_tanh_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_x,
    input  logic [7:0] data,
    input  logic       hi_en,
    input  logic       lo_en,
    output bf16_t      word,
    output logic       word_valid
);

    logic [7:0] hi_q;

    // word only changes when the low byte lands, so it keeps
    // showing the last complete entry while the next one arrives
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            hi_q       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= lo_en;
            if (hi_en) begin
                hi_q <= data;
            end
            if (lo_en) begin
                word <= {hi_q, data};
            end
        end
    end

endmodule

// File: rtl/bfloat16_tanh_loader.sv
// Streams NUM_ENTRIES bfloat16 tanh entries from a byte source into a table.
// Ports: clk, rst_x, start, s_data/s_valid/s_ready, load_* table write, busy, done, table_valid, cksum_err.
module bfloat16_tanh_loader
    import bfloat16_tanh_loader_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [15:0]       load_data,
    output logic [ADDR_W-1:0] load_addr,
    output logic              load_enable,
    output logic              busy,
    output logic              done,
    output logic              table_valid,
    output logic              cksum_err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_ENTRIES - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    bf16_t             csum;
    logic [7:0]        ck_hi;
    bf16_t             word;
    logic              word_valid;
    logic              xfer;
    logic              hi_en;
    logic              lo_en;

    // Moore outputs decoded straight from the state flops
    assign s_ready = (state == HI) || (state == LO) ||
                     (state == CK_HI) || (state == CK_LO);
    assign busy        = (state != IDLE);
    assign load_enable = (state == WRITE);
    assign done        = (state == FIN);
    assign load_data   = word;

    assign xfer  = s_valid && s_ready;
    assign hi_en = xfer && (state == HI);
    assign lo_en = xfer && (state == LO);

    byte_pair_assembler u_asm (
        .clk        (clk),
        .rst_x      (rst_x),
        .data       (s_data),
        .hi_en      (hi_en),
        .lo_en      (lo_en),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state       <= IDLE;
            cnt         <= '0;
            csum        <= '0;
            ck_hi       <= '0;
            load_addr   <= '0;
            table_valid <= 1'b0;
            cksum_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= HI;
                        cnt         <= '0;
                        csum        <= '0;
                        table_valid <= 1'b0;
                        cksum_err   <= 1'b0;
                    end
                end
                HI: begin
                    if (xfer) begin
                        state <= LO;
                    end
                end
                LO: begin
                    if (xfer) begin
                        state     <= WRITE;
                        load_addr <= cnt;
                    end
                end
                WRITE: begin
                    if (word_valid) begin
                        csum <= csum ^ word;
                    end
                    if (cnt == LAST) begin
                        state <= CK_HI;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= HI;
                    end
                end
                CK_HI: begin
                    if (xfer) begin
                        ck_hi <= s_data;
                        state <= CK_LO;
                    end
                end
                CK_LO: begin
                    // verdict is visible in the same cycle as done
                    if (xfer) begin
                        table_valid <= ({ck_hi, s_data} == csum);
                        cksum_err   <= ({ck_hi, s_data} != csum);
                        state       <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
